control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port opcode, input, 4 bits: the upper nibble of the instruction register.
REQ-004 The block SHALL have the ports carry and zero, inputs, 1 bit each: registered ALU flags.
REQ-005 The block SHALL have the output enables pc_oe_n, ram_oe_n, ir_oe_n, a_oe_n and alu_oe_n, outputs, 1 bit each, active-low: each drives the oc input of one tristate_register or bus driver.
REQ-006 The block SHALL have the load strobes mar_load, ram_load, ir_load, a_load, b_load, out_load and flags_load, outputs, 1 bit each, active-high.
REQ-007 The block SHALL have the outputs pc_inc, pc_load, alu_sub and halt, 1 bit each, active-high.
REQ-008 The block SHALL have the output step, 3 bits: current micro-step, 0 to 4.

Function
REQ-009 step SHALL be a registered counter that advances by 1 on each rising clk and returns to 0 after the last micro-step of the current instruction.
REQ-010 All control outputs SHALL be combinational decodes of (step, opcode, carry, zero), with no added latency; consuming registers act on the next rising edge.
REQ-011 Any output not listed for a step SHALL be inactive: every *_oe_n = 1, every other output = 0.
REQ-012 In step 0, the block SHALL assert pc_oe_n=0 and mar_load=1.
REQ-013 In step 1, the block SHALL assert ram_oe_n=0, ir_load=1 and pc_inc=1.
REQ-014 For opcode 0x1 (LDA), the block SHALL assert ir_oe_n=0 and mar_load in s2, ram_oe_n=0 and a_load in s3, and make s3 the last step.
REQ-015 For opcode 0x2 (ADD), the block SHALL assert ir_oe_n=0 and mar_load in s2, ram_oe_n=0 and b_load in s3, and alu_oe_n=0, a_load and flags_load in s4; s4 is the last step.
REQ-016 For opcode 0x3 (SUB), the block SHALL behave as ADD, with alu_sub=1 additionally asserted in s4 only.
REQ-017 For opcode 0x4 (STA), the block SHALL assert ir_oe_n=0 and mar_load in s2, a_oe_n=0 and ram_load in s3, and make s3 the last step.
REQ-018 For opcode 0x5 (LDI), the block SHALL assert ir_oe_n=0 and a_load in s2, and make s2 the last step.
REQ-019 For opcode 0x6 (JMP), the block SHALL assert ir_oe_n=0 and pc_load in s2, and make s2 the last step.
REQ-020 For opcode 0x7 (JC) and opcode 0x8 (JZ), the block SHALL assert ir_oe_n=0 and pc_load in s2 only if carry=1 (JC) or zero=1 (JZ); s2 is the last step whether or not the branch is taken.
REQ-021 For opcode 0xE (OUT), the block SHALL assert a_oe_n=0 and out_load in s2, and make s2 the last step.
REQ-022 For opcode 0x0 (NOP) and every undefined opcode, the block SHALL assert nothing in s2 and make s2 the last step.
REQ-023 For opcode 0xF (HLT) at s2, the block SHALL set an internal halted flag on the next edge; halt SHALL equal that flag.
REQ-024 While halted, step SHALL freeze at 2 and every control output SHALL be inactive until reset.
REQ-025 In every cycle, at most one *_oe_n SHALL be 0, so there is no bus contention.
REQ-026 opcode, carry and zero SHALL be ignored in steps 0 and 1.
REQ-027 step SHALL never exceed 4; if an illegal step value is reached, the next edge SHALL load 0.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force step=0 and halted=0, and hold every control output inactive, including the step-0 decode.
REQ-029 On the first rising clk after reset returns to 1, the step-0 decode SHALL be active and step SHALL advance normally.
REQ-030 Reset asserted mid-instruction or while halted SHALL abort immediately with no residual strobe.

Verification
REQ-031 The bench SHALL hold reset=0 for 17 time units and then release it, and SHALL check the step sequence 0,1,2,0 with opcode=0x0 and all step-0 and step-1 outputs as specified.
REQ-032 The bench SHALL apply opcode=0x2 and check steps 0 through 4 with flags_load=1 only in s4 and alu_sub=0; then apply opcode=0x3 and check alu_sub=1 only in s4.
REQ-033 The bench SHALL apply opcode=0x8 with zero=0 and check pc_load=0 in s2 and step returning to 0; then apply zero=1 and check pc_load=1 and ir_oe_n=0 in s2.
REQ-034 The bench SHALL apply opcode=0xF and check that halt=1 after s2, that step stays at 2 for at least 10 clocks with all outputs inactive, and that a reset pulse clears halt and gives step=0.
REQ-035 The bench SHALL drive reset low in s3 of an LDA and check that a_load drops immediately with step=0; after release, fetch SHALL restart at step 0.
REQ-036 The bench SHALL sweep all 16 opcodes and check in every cycle that no more than one *_oe_n is 0.

Source files
------------

// File: rtl/control_sequencer.sv
// Micro-step sequencer for the 8-bit bus machine: fetch in s0/s1, opcode-specific execute in s2..s4.
// All strobes are combinational decodes of the current step, so consumers act on the next rising edge.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output logic       pc_oe_n,
    output logic       ram_oe_n,
    output logic       ir_oe_n,
    output logic       a_oe_n,
    output logic       alu_oe_n,
    output logic       mar_load,
    output logic       ram_load,
    output logic       ir_load,
    output logic       a_load,
    output logic       b_load,
    output logic       out_load,
    output logic       flags_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       alu_sub,
    output logic       halt,
    output logic [2:0] step
);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] step_reg, step_next;
    logic [2:0] last_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            step_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    always_comb begin
        last_step  = 3'd2;
        case (opcode)
            OP_LDA, OP_STA: last_step = 3'd3;
            OP_ADD, OP_SUB: last_step = 3'd4;
            default:        last_step = 3'd2;
        endcase

        state_next = state_reg;
        step_next  = step_reg;
        // Once halted, the step register simply holds its value (2).
        if (state_reg == ST_RUN) begin
            if (step_reg > 3'd4) begin
                step_next = 3'd0;
            end else if (step_reg == 3'd2 && opcode == OP_HLT) begin
                state_next = ST_HALT;
            end else if (step_reg >= 3'd2 && step_reg >= last_step) begin
                step_next = 3'd0;
            end else begin
                step_next = step_reg + 3'd1;
            end
        end
    end

    always_comb begin
        pc_oe_n    = 1'b1;
        ram_oe_n   = 1'b1;
        ir_oe_n    = 1'b1;
        a_oe_n     = 1'b1;
        alu_oe_n   = 1'b1;
        mar_load   = 1'b0;
        ram_load   = 1'b0;
        ir_load    = 1'b0;
        a_load     = 1'b0;
        b_load     = 1'b0;
        out_load   = 1'b0;
        flags_load = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_sub    = 1'b0;
        // Gating with reset keeps the step-0 fetch strobes quiet while reset is held.
        if (reset && state_reg == ST_RUN) begin
            case (step_reg)
                3'd0: begin
                    pc_oe_n  = 1'b0;
                    mar_load = 1'b1;
                end
                3'd1: begin
                    ram_oe_n = 1'b0;
                    ir_load  = 1'b1;
                    pc_inc   = 1'b1;
                end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_oe_n  = 1'b0;
                            mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            ir_oe_n = 1'b0;
                            a_load  = 1'b1;
                        end
                        OP_JMP: begin
                            ir_oe_n = 1'b0;
                            pc_load = 1'b1;
                        end
                        OP_JC, OP_JZ: begin
                            if ((opcode == OP_JC) ? carry : zero) begin
                                ir_oe_n = 1'b0;
                                pc_load = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            a_oe_n   = 1'b0;
                            out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe_n = 1'b0;
                            a_load   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe_n = 1'b0;
                            b_load   = 1'b1;
                        end
                        OP_STA: begin
                            a_oe_n   = 1'b0;
                            ram_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_oe_n   = 1'b0;
                        a_load     = 1'b1;
                        flags_load = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign halt = (state_reg == ST_HALT);
    assign step = step_reg;

endmodule
